// File: rtl/slave_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency BRAM between two requesters.
// One access is in flight at a time. Read data is returned per requester with a 1-cycle rvalid.
module slave_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_wen,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,

  input  logic                  m1_req,
  input  logic                  m1_wen,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdata, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;          // 0 = m0, 1 = m1
  logic                  last_owner_q, last_owner_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that did not win last time gets the slot.
          owner_d      = (m0_req && m1_req) ? ~last_owner_q : m1_req;
          wen_d        = owner_d ? m1_wen   : m0_wen;
          addr_d       = owner_d ? m1_addr  : m0_addr;
          wdata_d      = owner_d ? m1_wdata : m0_wdata;
          last_owner_d = owner_d;
          state_d      = StAccess;
        end
      end
      StAccess: state_d = wen_q ? StIdle : StRdata;
      StRdata: begin
        if (owner_q) m1_rdata_d = mem_rdata;
        else         m0_rdata_d = mem_rdata;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    if (state_q == StAccess) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_wen   = wen_q;
      mem_ren   = ~wen_q;
      m0_gnt    = ~owner_q;
      m1_gnt    = owner_q;
    end
  end

  assign m0_rvalid = (state_q == StResp) && !owner_q;
  assign m1_rvalid = (state_q == StResp) && owner_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_slave_mem_arbiter.sv
// Bench for slave_mem_arbiter: directed scenarios plus randomized two-requester traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_slave_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RandCycles = 10000;

  logic          clk, rst;
  logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_wen, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wen, mem_ren, busy;

  int n_tests = 0;
  int n_fail  = 0;

  slave_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port BRAM with registered read; zero-filled on its first clock edge.
  logic [DW-1:0] bram [4096];
  logic          bram_init;
  always @(posedge clk) begin
    if (bram_init !== 1'b1) begin
      for (int i = 0; i < 4096; i++) bram[i] <= '0;
      bram_init <= 1'b1;
    end else begin
      if (mem_wen) bram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= bram[mem_addr];
    end
  end

  logic [42:0] all_outs;
  assign all_outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                     mem_addr, mem_wdata, mem_wen, mem_ren, busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%0b after 20 cycles, want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    n_tests++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rst = 1'b0;
    tick();
    // Write 0x5A to 0x010, read it back so m0_rdata is non-zero before the abort.
    m0_req = 1; m0_wen = 1; m0_addr = 12'h010; m0_wdata = 8'h5A;
    tick();
    m0_req = 0;
    tick();
    m0_req = 1; m0_wen = 0;
    tick();
    m0_req = 0;
    tick();
    tick();
    n_tests++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_preread: rvalid=%0b rdata=%h want 1/5a", m0_rvalid, m0_rdata);
    end
    tick();
    m0_req = 1;
    tick();
    m0_req = 0;
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_mid_read: got %h want 0", all_outs);
    end
    tick();
    n_tests++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_held: got %h want 0", all_outs);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (m0_rvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resp: rvalid=%0b busy=%0b want 0/0", m0_rvalid, busy);
    end
    m0_req = 1; m0_wen = 0; m0_addr = 12'h010;
    m1_req = 1; m1_wen = 0; m1_addr = 12'h010;
    tick();
    n_tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_tie: m0_gnt=%0b m1_gnt=%0b want 1/0", m0_gnt, m1_gnt);
    end
    clear_reqs();
    wait_idle("reset");
  endtask

  task automatic test_write();
    m0_req = 1; m0_wen = 1; m0_addr = 12'h123; m0_wdata = 8'hA5;
    tick();
    n_tests++;
    if ({m0_gnt, m1_gnt, mem_wen, mem_ren, busy} !== 5'b10101 ||
        mem_addr !== 12'h123 || mem_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_issue: gnt=%0b%0b wen=%0b ren=%0b addr=%h wdata=%h want 10 1 0 123 a5",
               m0_gnt, m1_gnt, mem_wen, mem_ren, mem_addr, mem_wdata);
    end
    clear_reqs();
    tick();
    n_tests++;
    if (busy !== 1'b0 || mem_wen !== 1'b0 || m0_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL write_done: busy=%0b wen=%0b gnt=%0b want 0/0/0", busy, mem_wen, m0_gnt);
    end
  endtask

  task automatic test_read();
    m0_req = 1; m0_wen = 0; m0_addr = 12'h123;
    tick();
    n_tests++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 12'h123 || m0_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL read_issue: ren=%0b wen=%0b addr=%h gnt=%0b want 1 0 123 1",
               mem_ren, mem_wen, mem_addr, m0_gnt);
    end
    clear_reqs();
    tick();
    n_tests++;
    if (m0_rvalid !== 1'b0 || mem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL read_early: rvalid=%0b ren=%0b want 0/0", m0_rvalid, mem_ren);
    end
    tick();
    n_tests++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_resp: rvalid=%0b%0b rdata=%h want 10 a5", m0_rvalid, m1_rvalid, m0_rdata);
    end
    tick();
    n_tests++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 8'hA5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hold: rvalid=%0b rdata=%h busy=%0b want 0 a5 0", m0_rvalid, m0_rdata, busy);
    end
  endtask

  task automatic test_contention();
    bit order[$];
    int gcyc[$];
    int rv0 = 0;
    int rv1 = 0;
    pulse_reset();
    m1_req = 1; m1_wen = 1; m1_addr = 12'h020; m1_wdata = 8'hC3;
    tick();
    clear_reqs();
    tick();
    m0_req = 1; m0_wen = 0; m0_addr = 12'h010;
    m1_req = 1; m1_wen = 0; m1_addr = 12'h020;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (m0_gnt) begin order.push_back(1'b0); gcyc.push_back(c); end
      if (m1_gnt) begin order.push_back(1'b1); gcyc.push_back(c); end
      if (m0_rvalid) begin
        rv0++;
        n_tests++;
        if (m0_rdata !== 8'h5A || m1_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL cont_m0_data: rdata=%h m1_rvalid=%0b want 5a/0", m0_rdata, m1_rvalid);
        end
      end
      if (m1_rvalid) begin
        rv1++;
        n_tests++;
        if (m1_rdata !== 8'hC3 || m0_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL cont_m1_data: rdata=%h m0_rvalid=%0b want c3/0", m1_rdata, m0_rvalid);
        end
      end
      if (order.size() >= 4) clear_reqs();
      if (order.size() >= 4 && rv0 + rv1 >= 4) break;
    end
    n_tests++;
    if (order.size() != 4 || order[0] !== 1'b0 || order[1] !== 1'b1 ||
        order[2] !== 1'b0 || order[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_order: got %p want '{0,1,0,1}", order);
    end
    n_tests++;
    if (gcyc.size() != 4 || gcyc[1] - gcyc[0] != 4 || gcyc[3] - gcyc[2] != 4) begin
      n_fail++;
      $display("FAIL cont_spacing: grant cycles %p want spacing 4", gcyc);
    end
    n_tests++;
    if (rv0 != 2 || rv1 != 2) begin
      n_fail++;
      $display("FAIL cont_rvalid_count: m0=%0d m1=%0d want 2/2", rv0, rv1);
    end
    wait_idle("contention");
  endtask

  task automatic test_back_to_back();
    m1_req = 1; m1_wen = 1; m1_addr = 12'hFFF; m1_wdata = 8'h3C;
    tick();
    n_tests++;
    if (m1_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 12'hFFF) begin
      n_fail++;
      $display("FAIL b2b_write: gnt=%0b wen=%0b addr=%h want 1 1 fff", m1_gnt, mem_wen, mem_addr);
    end
    m1_wen = 0; m1_wdata = 8'h00;
    tick();
    n_tests++;
    if (busy !== 1'b0 || mem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: busy=%0b ren=%0b want 0/0", busy, mem_ren);
    end
    tick();
    n_tests++;
    if (m1_gnt !== 1'b1 || mem_ren !== 1'b1 || mem_addr !== 12'hFFF) begin
      n_fail++;
      $display("FAIL b2b_read_issue: gnt=%0b ren=%0b addr=%h want 1 1 fff", m1_gnt, mem_ren, mem_addr);
    end
    clear_reqs();
    tick();
    tick();
    n_tests++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h3C || m0_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read_data: rvalid=%0b rdata=%h m0_rvalid=%0b want 1 3c 0",
               m1_rvalid, m1_rdata, m0_rvalid);
    end
    wait_idle("b2b");
  endtask

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_rd_t;

  task automatic test_random();
    exp_rd_t       expq[$];
    exp_rd_t       e;
    logic [DW-1:0] ref_mem [16];
    bit            pend [2];
    bit            pwen [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pwd [2];
    bit            last_gnt;
    bit            s0, s1, pb, issue, exp_owner, r;
    logic [DW-1:0] rd;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pwen[i] = 0; paddr[i] = '0; pwd[i] = '0;
    end
    pulse_reset();
    last_gnt = 1'b1;
    for (int unsigned c = 0; c < RandCycles; c++) begin
      s0 = m0_req; s1 = m1_req; pb = busy;
      tick();
      n_tests++;
      if ((mem_wen && mem_ren) || (m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid)) begin
        n_fail++;
        $display("FAIL rand_mutex cyc %0d: wen/ren=%0b%0b gnt=%0b%0b rvalid=%0b%0b want exclusive",
                 c, mem_wen, mem_ren, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
      end
      issue = !pb && (s0 || s1);
      n_tests++;
      if ((m0_gnt || m1_gnt) !== issue) begin
        n_fail++;
        $display("FAIL rand_gnt_timing cyc %0d: gnt=%0b%0b want issue=%0b", c, m0_gnt, m1_gnt, issue);
      end
      if (issue && (m0_gnt ^ m1_gnt)) begin
        exp_owner = (s0 && s1) ? !last_gnt : s1;
        r = m1_gnt;
        n_tests++;
        if (r !== exp_owner) begin
          n_fail++;
          $display("FAIL rand_owner cyc %0d: got m%0d want m%0d", c, r, exp_owner);
        end
        last_gnt = r;
        n_tests++;
        if (!pend[r] || mem_addr !== paddr[r] || mem_wen !== pwen[r] || mem_ren !== !pwen[r] ||
            (pwen[r] && mem_wdata !== pwd[r])) begin
          n_fail++;
          $display("FAIL rand_issue cyc %0d m%0d: addr=%h wen=%0b ren=%0b wdata=%h want %h %0b %0b %h",
                   c, r, mem_addr, mem_wen, mem_ren, mem_wdata, paddr[r], pwen[r], !pwen[r], pwd[r]);
        end
        if (pwen[r]) begin
          ref_mem[paddr[r][3:0]] = pwd[r];
        end else begin
          e.owner = r; e.data = ref_mem[paddr[r][3:0]]; e.cyc = c + 2;
          expq.push_back(e);
        end
        pend[r] = 0;
      end
      if (m0_rvalid || m1_rvalid) begin
        r  = m1_rvalid;
        rd = r ? m1_rdata : m0_rdata;
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL rand_rvalid cyc %0d: rvalid on m%0d with no read outstanding", c, r);
        end else begin
          e = expq.pop_front();
          if (r !== e.owner || rd !== e.data || c != e.cyc) begin
            n_fail++;
            $display("FAIL rand_rdata cyc %0d: m%0d data=%h want m%0d data=%h at cyc %0d",
                     c, r, rd, e.owner, e.data, e.cyc);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < RandCycles - 30 && $urandom_range(2) == 0) begin
          pend[i]  = 1;
          pwen[i]  = $urandom_range(1) == 1;
          paddr[i] = 12'h400 | 12'($urandom_range(15));
          pwd[i]   = 8'($urandom_range(255));
        end
      end
      m0_req = pend[0]; m0_wen = pwen[0]; m0_addr = paddr[0]; m0_wdata = pwd[0];
      m1_req = pend[1]; m1_wen = pwen[1]; m1_addr = paddr[1]; m1_wdata = pwd[1];
    end
    n_tests++;
    if (expq.size() != 0 || pend[0] || pend[1]) begin
      n_fail++;
      $display("FAIL rand_drain: reads outstanding=%0d pending=%0b%0b want 0 00",
               expq.size(), pend[0], pend[1]);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (bram[12'h400 + i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL rand_mem[%h]: got %h want %h", 12'h400 + i, bram[12'h400 + i], ref_mem[i]);
      end
    end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
